// File: rtl/reg_scoreboard_ctrl_if.sv
// Issue/retire/flush bundle between decode, writeback and the register scoreboard.
// The decode-side controller drives through master; the scoreboard is the slave.
interface reg_scoreboard_ctrl_if #(
  parameter int NUM_REGS = 8
);
  localparam int REG_W = $clog2(NUM_REGS);

  logic             issue_valid;
  logic [3:0]       issue_opcode;
  logic [REG_W-1:0] issue_sr1;
  logic             issue_sr1_needed;
  logic [REG_W-1:0] issue_sr2;
  logic             issue_sr2_needed;
  logic             issue_ld_reg;
  logic [REG_W-1:0] issue_drid;
  logic             issue_ld_cc;

  logic             wb_valid;
  logic             wb_ld_reg;
  logic [REG_W-1:0] wb_drid;
  logic             wb_ld_cc;

  logic             flush;

  logic                issue_stall;
  logic                issue_fire;
  logic [NUM_REGS-1:0] pending_regs;
  logic                cc_pending;
  logic                sb_error;

  modport master (
    output issue_valid, issue_opcode, issue_sr1, issue_sr1_needed,
           issue_sr2, issue_sr2_needed, issue_ld_reg, issue_drid, issue_ld_cc,
           wb_valid, wb_ld_reg, wb_drid, wb_ld_cc, flush,
    input  issue_stall, issue_fire, pending_regs, cc_pending, sb_error
  );

  modport slave (
    input  issue_valid, issue_opcode, issue_sr1, issue_sr1_needed,
           issue_sr2, issue_sr2_needed, issue_ld_reg, issue_drid, issue_ld_cc,
           wb_valid, wb_ld_reg, wb_drid, wb_ld_cc, flush,
    output issue_stall, issue_fire, pending_regs, cc_pending, sb_error
  );
endinterface

// File: rtl/reg_scoreboard_ctrl.sv
// Register scoreboard for the LC-3b decode stage: one pending-writer counter per GPR
// plus one for the condition codes, producing the decode stall and issue-fire qualifiers.
module reg_scoreboard_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  reg_scoreboard_ctrl_if.slave sb
);
  localparam logic [3:0]       OP_BR   = 4'b0000;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int               REG_W   = $clog2(NUM_REGS);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [CNT_W-1:0]    cc_cnt_q;
  logic [CNT_W-1:0]    cc_cnt_d;
  logic                sb_error_q;
  logic                underflow;
  logic [NUM_REGS-1:0] reg_busy;
  logic [NUM_REGS-1:0] reg_inc;
  logic [NUM_REGS-1:0] reg_dec;
  logic                cc_busy;
  logic                cc_inc;
  logic                cc_dec;
  logic                stall;
  logic                fire;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_busy[i] = (cnt_q[i] != '0);
    end
  end

  assign cc_busy = (cc_cnt_q != '0);

  // Only counters that predate this instruction are consulted, so an instruction
  // whose destination matches its own source never stalls on itself.
  always_comb begin
    stall = 1'b0;
    if (sb.issue_valid) begin
      stall = (sb.issue_sr1_needed && reg_busy[sb.issue_sr1])
           || (sb.issue_sr2_needed && reg_busy[sb.issue_sr2])
           || ((sb.issue_opcode == OP_BR) && cc_busy)
           || (sb.issue_ld_reg && (cnt_q[sb.issue_drid] == CNT_MAX))
           || (sb.issue_ld_cc && (cc_cnt_q == CNT_MAX));
    end
  end

  assign fire = sb.issue_valid && !stall && !sb.flush;

  always_comb begin
    reg_inc = '0;
    reg_dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_inc[i] = fire && sb.issue_ld_reg && (sb.issue_drid == REG_W'(i));
      reg_dec[i] = sb.wb_valid && sb.wb_ld_reg && (sb.wb_drid == REG_W'(i));
    end
  end

  assign cc_inc = fire && sb.issue_ld_cc;
  assign cc_dec = sb.wb_valid && sb.wb_ld_cc;

  // A flush wins over everything, including a retire that would otherwise underflow.
  always_comb begin
    underflow = 1'b0;
    cc_cnt_d  = cc_cnt_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (sb.flush) begin
      cc_cnt_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_inc[i] && !reg_dec[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else if (reg_dec[i] && !reg_inc[i]) begin
          if (cnt_q[i] == '0) begin
            underflow = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
      end
      if (cc_inc && !cc_dec) begin
        cc_cnt_d = cc_cnt_q + CNT_ONE;
      end else if (cc_dec && !cc_inc) begin
        if (cc_cnt_q == '0) begin
          underflow = 1'b1;
        end else begin
          cc_cnt_d = cc_cnt_q - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      cc_cnt_q   <= '0;
      sb_error_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      cc_cnt_q <= cc_cnt_d;
      if (underflow) begin
        sb_error_q <= 1'b1;
      end
    end
  end

  assign sb.issue_stall  = stall;
  assign sb.issue_fire   = fire;
  assign sb.pending_regs = reg_busy;
  assign sb.cc_pending   = cc_busy;
  assign sb.sb_error     = sb_error_q;

endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Bench for reg_scoreboard_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against an in-flight-count model.
module tb_reg_scoreboard_ctrl;
  localparam int NR   = 8;
  localparam int CMAX = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_scoreboard_ctrl_if #(.NUM_REGS(NR)) sbif ();

  reg_scoreboard_ctrl #(.NUM_REGS(NR), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sbif)
  );

  // Model: number of issued-but-not-retired writers per resource.
  int m_cnt [NR];
  int m_cc;
  bit m_err;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    if (!sbif.issue_valid) return 1'b0;
    if (sbif.issue_sr1_needed && m_cnt[sbif.issue_sr1] != 0) return 1'b1;
    if (sbif.issue_sr2_needed && m_cnt[sbif.issue_sr2] != 0) return 1'b1;
    if (sbif.issue_opcode == 4'd0 && m_cc != 0) return 1'b1;
    if (sbif.issue_ld_reg && m_cnt[sbif.issue_drid] == CMAX) return 1'b1;
    if (sbif.issue_ld_cc && m_cc == CMAX) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_fire();
    return sbif.issue_valid && !m_stall() && !sbif.flush;
  endfunction

  function automatic int m_pending();
    int p = 0;
    for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) p |= (1 << i);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    m_cc  = 0;
    m_err = 1'b0;
  endtask

  task automatic model_update();
    bit f;
    bit inc;
    bit dec;
    f = m_fire();
    if (sbif.flush) begin
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_cc = 0;
      return;
    end
    for (int i = 0; i < NR; i++) begin
      inc = f && sbif.issue_ld_reg && (int'(sbif.issue_drid) == i);
      dec = sbif.wb_valid && sbif.wb_ld_reg && (int'(sbif.wb_drid) == i);
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc) begin
        if (m_cnt[i] == 0) m_err = 1'b1;
        else m_cnt[i]--;
      end
    end
    inc = f && sbif.issue_ld_cc;
    dec = sbif.wb_valid && sbif.wb_ld_cc;
    if (inc && !dec) m_cc++;
    else if (dec && !inc) begin
      if (m_cc == 0) m_err = 1'b1;
      else m_cc--;
    end
  endtask

  task automatic compare_all();
    chk("issue_stall",  int'(sbif.issue_stall),  int'(m_stall()));
    chk("issue_fire",   int'(sbif.issue_fire),   int'(m_fire()));
    chk("pending_regs", int'(sbif.pending_regs), m_pending());
    chk("cc_pending",   int'(sbif.cc_pending),   int'(m_cc != 0));
    chk("sb_error",     int'(sbif.sb_error),     int'(m_err));
  endtask

  // Inputs change at posedge+1; compare at negedge; model advances at posedge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_issue(input int op, input int sr1, input int sr1n, input int sr2,
                           input int sr2n, input int ld_reg, input int drid, input int ld_cc);
    sbif.issue_valid      = 1'b1;
    sbif.issue_opcode     = 4'(op);
    sbif.issue_sr1        = 3'(sr1);
    sbif.issue_sr1_needed = 1'(sr1n);
    sbif.issue_sr2        = 3'(sr2);
    sbif.issue_sr2_needed = 1'(sr2n);
    sbif.issue_ld_reg     = 1'(ld_reg);
    sbif.issue_drid       = 3'(drid);
    sbif.issue_ld_cc      = 1'(ld_cc);
  endtask

  task automatic no_issue();
    sbif.issue_valid      = 1'b0;
    sbif.issue_opcode     = 4'd1;
    sbif.issue_sr1        = 3'd0;
    sbif.issue_sr1_needed = 1'b0;
    sbif.issue_sr2        = 3'd0;
    sbif.issue_sr2_needed = 1'b0;
    sbif.issue_ld_reg     = 1'b0;
    sbif.issue_drid       = 3'd0;
    sbif.issue_ld_cc      = 1'b0;
  endtask

  task automatic set_wb(input int v, input int ld_reg, input int drid, input int ld_cc);
    sbif.wb_valid  = 1'(v);
    sbif.wb_ld_reg = 1'(ld_reg);
    sbif.wb_drid   = 3'(drid);
    sbif.wb_ld_cc  = 1'(ld_cc);
  endtask

  task automatic idle_all();
    no_issue();
    set_wb(0, 0, 0, 0);
    sbif.flush = 1'b0;
  endtask

  int pend_list [$];
  int pick;

  initial begin
    model_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pending_regs", int'(sbif.pending_regs), 0);
    chk("reset cc_pending",   int'(sbif.cc_pending),   0);
    chk("reset issue_stall",  int'(sbif.issue_stall),  0);
    chk("reset issue_fire",   int'(sbif.issue_fire),   0);
    chk("reset sb_error",     int'(sbif.sb_error),     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD R1 <- R2,R3 writing CC
    set_issue(1, 2, 1, 3, 1, 1, 1, 1);
    #1;
    chk("add fire", int'(sbif.issue_fire), 1);
    tick();
    // ADD R4 <- R1 depends on R1
    set_issue(1, 1, 1, 0, 0, 1, 4, 0);
    #1;
    chk("add pending", int'(sbif.pending_regs), 'h02);
    chk("add cc_pending", int'(sbif.cc_pending), 1);
    chk("raw stall", int'(sbif.issue_stall), 1);
    tick();
    set_wb(1, 1, 1, 1);
    #1;
    chk("no bypass stall", int'(sbif.issue_stall), 1);
    tick();
    set_wb(0, 0, 0, 0);
    #1;
    chk("raw released stall", int'(sbif.issue_stall), 0);
    chk("raw released fire", int'(sbif.issue_fire), 1);
    tick();
    no_issue();
    #1;
    chk("r4 pending", int'(sbif.pending_regs), 'h10);
    chk("cc retired", int'(sbif.cc_pending), 0);
    tick();

    // BR behind a CC writer
    set_issue(5, 0, 0, 0, 0, 0, 0, 1);
    tick();
    set_issue(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("br stall", int'(sbif.issue_stall), 1);
    tick();
    set_wb(1, 0, 0, 1);
    #1;
    chk("br stall during wb", int'(sbif.issue_stall), 1);
    tick();
    set_wb(0, 0, 0, 0);
    #1;
    chk("br released", int'(sbif.issue_stall), 0);
    chk("br cc_pending", int'(sbif.cc_pending), 0);
    tick();

    // Saturation of R5
    set_issue(1, 0, 0, 0, 0, 1, 5, 0);
    tick();
    tick();
    set_wb(1, 1, 5, 0);
    #1;
    chk("r5 issue+wb fire", int'(sbif.issue_fire), 1);
    tick();
    set_wb(0, 0, 0, 0);
    tick();
    #1;
    chk("r5 saturation stall", int'(sbif.issue_stall), 1);
    chk("r5 pending", int'(sbif.pending_regs), 'h30);
    tick();
    set_wb(1, 1, 5, 0);
    #1;
    chk("r5 stall during wb", int'(sbif.issue_stall), 1);
    tick();
    set_wb(0, 0, 0, 0);
    #1;
    chk("r5 fourth fires", int'(sbif.issue_fire), 1);
    tick();

    // Flush with R1 twice pending and CC pending; retire to empty R7 ignored
    set_issue(1, 0, 0, 0, 0, 1, 1, 1);
    tick();
    set_issue(1, 0, 0, 0, 0, 1, 1, 0);
    tick();
    set_issue(1, 0, 0, 0, 0, 1, 2, 0);
    set_wb(1, 1, 7, 1);
    sbif.flush = 1'b1;
    #1;
    chk("flush fire", int'(sbif.issue_fire), 0);
    tick();
    idle_all();
    #1;
    chk("flush pending", int'(sbif.pending_regs), 0);
    chk("flush cc_pending", int'(sbif.cc_pending), 0);
    chk("flush sb_error", int'(sbif.sb_error), 0);
    tick();

    // Underflow on R6
    set_wb(1, 1, 6, 0);
    tick();
    set_wb(0, 0, 0, 0);
    #1;
    chk("underflow sb_error", int'(sbif.sb_error), 1);
    chk("underflow pending", int'(sbif.pending_regs), 0);
    tick();
    tick();
    #1;
    chk("sb_error sticky", int'(sbif.sb_error), 1);

    // Asynchronous reset mid-run
    set_issue(1, 0, 0, 0, 0, 1, 3, 1);
    tick();
    idle_all();
    rst_n = 1'b0;
    #2;
    chk("async pending", int'(sbif.pending_regs), 0);
    chk("async cc_pending", int'(sbif.cc_pending), 0);
    chk("async sb_error", int'(sbif.sb_error), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) != 0)
        set_issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2) == 0));
      else
        no_issue();
      pend_list.delete();
      for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) pend_list.push_back(i);
      if (pend_list.size() != 0 && $urandom_range(0, 7) != 0)
        pick = pend_list[$urandom_range(0, pend_list.size() - 1)];
      else
        pick = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) != 0)
        set_wb(1, int'($urandom_range(0, 3) != 0), pick,
               int'(m_cc != 0 ? $urandom_range(0, 1) : ($urandom_range(0, 15) == 0)));
      else
        set_wb(0, int'($urandom_range(0, 1)), pick, int'($urandom_range(0, 1)));
      sbif.flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle_all();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard_ctrl.md
Name: reg_scoreboard_ctrl

Overview:
- Counter-based hazard scheduler for the LC-3b pipeline's decode stage; replaces per-stage destination comparators with a register scoreboard.
- Tracks in-flight writers of each GPR and of the condition codes between issue and writeback.
- Produces the decode stall and issue-fire qualifiers.
- Sits between decode (issue side) and writeback (retire side); the pipeline control unit owns `flush`.

Parameters:
- `NUM_REGS`, 8, number of GPRs tracked (index width 3, matches `lc3b_reg`).
- `CNT_W`, 2, width of each pending-writer counter; max in-flight writers per resource = 2^CNT_W-1.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `issue_valid` in 1: decode holds a valid instruction.
- `issue_opcode` in `lc3b_opcode`: decode opcode.
- `issue_sr1` in 3: source reg 1.
- `issue_sr1_needed` in 1: sr1 is read.
- `issue_sr2` in 3: source reg 2.
- `issue_sr2_needed` in 1: sr2 is read.
- `issue_ld_reg` in 1: instruction writes a GPR.
- `issue_drid` in 3: destination reg.
- `issue_ld_cc` in 1: instruction writes CC.
- `wb_valid` in 1: writeback stage retires an instruction this cycle.
- `wb_ld_reg` in 1: retiring instruction writes a GPR.
- `wb_drid` in 3: retiring destination.
- `wb_ld_cc` in 1: retiring instruction writes CC.
- `flush` in 1: pipeline emptied (all in-flight squashed).
- `issue_stall` out 1: hold decode.
- `issue_fire` out 1: instruction leaves decode this cycle.
- `pending_regs` out `NUM_REGS`: bit i = counter i nonzero.
- `cc_pending` out 1: CC counter nonzero.
- `sb_error` out 1: sticky underflow flag.

Behaviour:
- State: `cnt[0..7]` (`CNT_W` bits each), `cc_cnt` (`CNT_W` bits), `sb_error` (1 bit).
- Reset (`rst_n`=0, async): all counters 0 and `sb_error`=0.
- Outputs after reset: `pending_regs`=0, `cc_pending`=0, `issue_stall`=0, `issue_fire`=0.
- `issue_stall` is combinational from registered counters and current issue inputs; it is asserted when `issue_valid`=1 and any of:
  - a. `issue_sr1_needed` and `cnt[issue_sr1]`!=0.
  - b. `issue_sr2_needed` and `cnt[issue_sr2]`!=0.
  - c. `issue_opcode`==`op_br` and `cc_cnt`!=0.
  - d. `issue_ld_reg` and `cnt[issue_drid]`==max (saturation guard).
  - e. `issue_ld_cc` and `cc_cnt`==max.
- `issue_stall`=0 whenever `issue_valid`=0.
- `issue_fire` = `issue_valid` & ~`issue_stall` & ~`flush`.
- No same-cycle bypass: a writeback in cycle N clears pending state at edge N+1. The first non-stalled issue of a dependent instruction is cycle N+1, matching regfile write-at-edge.
- Update per edge, per counter:
  - inc = `issue_fire` & `ld` & (`drid`==i).
  - dec = `wb_valid` & `wb_ld` & (`wb_drid`==i).
  - inc&dec: hold. inc only: +1. dec only: -1.
  - The CC counter uses the same rule with `issue_ld_cc`/`wb_ld_cc`.
- Underflow (dec on a zero counter with no inc): counter holds 0 and `sb_error` sets. It stays set until reset.
- Overflow cannot occur: rule d/e blocks the inc.
- `flush`=1:
  - All counters clear to 0 at the next edge, regardless of issue/wb inputs that cycle.
  - `issue_fire` is forced 0.
  - A retire in the flush cycle is ignored and does not flag underflow.
  - `sb_error` is unaffected.
- `pending_regs` and `cc_pending` derive from registered counters, so they are valid one cycle after each update.
- An instruction with `issue_ld_reg` whose `drid` equals its own sr1/sr2 stalls only on prior writers, never on itself.

Test Plan:
- Reset then `issue_valid`=1, ADD R1←R2,R3 (`ld_reg`, `drid`=1, `ld_cc`) → `issue_fire`=1. Next cycle `pending_regs`=0x02, `cc_pending`=1.
- Following cycle issue ADD R4←R1 (`sr1`=1 needed) → `issue_stall`=1 until the cycle after `wb_valid`/`wb_drid`=1. Then `issue_fire`=1 and `pending_regs`=0x10.
- BR with `cc_cnt`=1 → `issue_stall`=1; `wb_ld_cc` pulse → stall drops next cycle, `cc_pending`=0.
- Three back-to-back writers of R5 (`CNT_W`=2) → `cnt[5]`=3. A fourth writer stalls (rule d). A simultaneous issue+wb of R5 keeps `cnt[5]`=3 and the fourth fires the cycle after a lone wb.
- `wb_valid`, `wb_ld_reg`, `wb_drid`=6 with `cnt[6]`=0 → `sb_error`=1 sticky, `cnt[6]` stays 0. `rst_n` low mid-run → all counters and `sb_error` 0 immediately, without waiting for a clock edge.
- `flush` with `cnt[1]`=2, `cc_cnt`=1 and concurrent `issue_valid`+wb → `issue_fire`=0. Next cycle `pending_regs`=0, `cc_pending`=0, `sb_error` unchanged.
